// File: rtl/serial_adder_if.sv
// Start/done handshake and operand/result bundle for the bit-serial adder.
// The master drives the request; the adder (slave) returns status and results.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output start, sub, a, b,
        input  busy, done, sum, c_out, ovf
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, sum, c_out, ovf
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one full-adder slice, LSB first, registered carry.
// Results and flags update only on the completion edge and are held until the next one.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_adder_if.slave bus
);
    //  state | meaning
    //  IDLE  | waiting for start; operands captured on acceptance
    //  RUN   | one bit per edge, counter tracks the bit being processed
    //  DONE  | results valid, done pulse; returns to IDLE unconditionally
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic bit_s;
    logic bit_c;

    assign bit_s = a_q[0] ^ b_q[0] ^ cy_q;
    assign bit_c = (a_q[0] & b_q[0]) | (a_q[0] & cy_q) | (b_q[0] & cy_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    a_d     = bus.a;
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    cy_d    = bus.sub;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cy_d  = bit_c;
                res_d = {bit_s, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    // cy_q here is the carry into the MSB, bit_c the carry out of it
                    state_d = ST_DONE;
                    sum_d   = {bit_s, res_q[WIDTH-1:1]};
                    c_out_d = bit_c;
                    ovf_d   = cy_q ^ bit_c;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy  = (state_q != ST_IDLE);
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
    assign bus.ovf   = ovf_q;
endmodule
